// File: rtl/regfile_2r1w_clr.sv
// regfile_2r1w_clr: 2-read/1-write register file with valid bits, optional bypass and zero register, and a run-time clear sweep
module regfile_2r1w_clr #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              clear_i,
  output logic              busy_o,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic              rd_valid_a_o,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic              rd_valid_b_o
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic              rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;
  logic              we, zero_a, zero_b, byp_a, byp_b;
  assign we     = write_i && state_q == IDLE && !(ZERO_REG && wr_addr_i == '0);
  assign zero_a = ZERO_REG && rd_addr_a_i == '0;
  assign zero_b = ZERO_REG && rd_addr_b_i == '0;
  assign byp_a  = BYPASS && we && wr_addr_i == rd_addr_a_i;
  assign byp_b  = BYPASS && we && wr_addr_i == rd_addr_b_i;
  assign busy_o       = state_q == CLEAR;
  assign wr_ready_o   = state_q == IDLE;
  assign rd_data_a_o  = rd_data_a_q;
  assign rd_valid_a_o = rd_valid_a_q;
  assign rd_data_b_o  = rd_data_b_q;
  assign rd_valid_b_o = rd_valid_b_q;
  // Sweep sequencing and read-port selection (zero register, then bypass, then storage)
  always_comb begin
    state_d      = state_q == IDLE ? (clear_i ? CLEAR : IDLE) : (&cnt_q ? IDLE : CLEAR);
    cnt_d        = state_q == CLEAR ? cnt_q + 1'b1 : '0;
    rd_data_a_d  = zero_a ? '0 : byp_a ? wr_data_i : mem_q[rd_addr_a_i];
    rd_valid_a_d = zero_a || byp_a || valid_q[rd_addr_a_i];
    rd_data_b_d  = zero_b ? '0 : byp_b ? wr_data_i : mem_q[rd_addr_b_i];
    rd_valid_b_d = zero_b || byp_b || valid_q[rd_addr_b_i];
  end
  // Clear FSM state and sweep counter
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // Storage: sweep erases one entry per cycle, otherwise accepted writes land
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q <= '0;
    end else if (state_q == CLEAR) begin
      mem_q[cnt_q]   <= '0;
      valid_q[cnt_q] <= 1'b0;
    end else if (we) begin
      mem_q[wr_addr_i]   <= wr_data_i;
      valid_q[wr_addr_i] <= 1'b1;
    end
  // Registered read ports
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rd_data_a_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_data_b_q  <= '0;
      rd_valid_b_q <= 1'b0;
    end else begin
      rd_data_a_q  <= rd_data_a_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_b_q <= rd_valid_b_d;
    end
endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// tb_regfile_2r1w_clr: directed and random checks of two register file configurations against an array model
module tb_regfile_2r1w_clr;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic        w0, c0, wrr0, busy0, rva0, rvb0;
  logic [2:0]  wa0, ra0, rb0;
  logic [15:0] wd0, rda0, rdb0;
  logic        w1, c1, wrr1, busy1, rva1, rvb1;
  logic [3:0]  wa1, ra1, rb1;
  logic [31:0] wd1, rda1, rdb1;
  regfile_2r1w_clr dut0 (
    .clk_i(clk), .rst_ni(rst_n), .write_i(w0), .wr_addr_i(wa0), .wr_data_i(wd0),
    .wr_ready_o(wrr0), .clear_i(c0), .busy_o(busy0),
    .rd_addr_a_i(ra0), .rd_data_a_o(rda0), .rd_valid_a_o(rva0),
    .rd_addr_b_i(rb0), .rd_data_b_o(rdb0), .rd_valid_b_o(rvb0)
  );
  regfile_2r1w_clr #(.DATA_W(32), .ADDR_W(4), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .write_i(w1), .wr_addr_i(wa1), .wr_data_i(wd1),
    .wr_ready_o(wrr1), .clear_i(c1), .busy_o(busy1),
    .rd_addr_a_i(ra1), .rd_data_a_o(rda1), .rd_valid_a_o(rva1),
    .rd_addr_b_i(rb1), .rd_data_b_o(rdb1), .rd_valid_b_o(rvb1)
  );
  int checks = 0;
  int failures = 0;
  logic [15:0] m0 [8];
  logic        v0 [8];
  int          sw0;
  logic [31:0] m1 [16];
  logic        v1 [16];
  int          sw1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic clear_models();
    for (int i = 0; i < 8; i++) begin m0[i] = '0; v0[i] = 1'b0; end
    for (int i = 0; i < 16; i++) begin m1[i] = '0; v1[i] = 1'b0; end
    sw0 = 0;
    sw1 = 0;
  endtask
  task automatic step0(input logic w, input logic [2:0] wa, input logic [15:0] wd, input logic c,
                       input logic [2:0] ra, input logic [2:0] rb);
    logic acc, eva, evb;
    logic [15:0] ea, eb;
    w0 = w; wa0 = wa; wd0 = wd; c0 = c; ra0 = ra; rb0 = rb;
    acc = w && sw0 == 0;
    ea  = (acc && wa == ra) ? wd : m0[ra];
    eva = (acc && wa == ra) ? 1'b1 : v0[ra];
    eb  = (acc && wa == rb) ? wd : m0[rb];
    evb = (acc && wa == rb) ? 1'b1 : v0[rb];
    @(posedge clk);
    if (acc) begin m0[wa] = wd; v0[wa] = 1'b1; end
    if (sw0 > 0) begin m0[8-sw0] = '0; v0[8-sw0] = 1'b0; sw0--; end
    else if (c) sw0 = 8;
    #1;
    chk("d0_rd_data_a", 32'(rda0), 32'(ea));
    chk("d0_rd_valid_a", 32'(rva0), 32'(eva));
    chk("d0_rd_data_b", 32'(rdb0), 32'(eb));
    chk("d0_rd_valid_b", 32'(rvb0), 32'(evb));
    chk("d0_busy", 32'(busy0), 32'(sw0 > 0));
    chk("d0_wr_ready", 32'(wrr0), 32'(sw0 == 0));
    w0 = 1'b0; c0 = 1'b0;
  endtask
  task automatic step1(input logic w, input logic [3:0] wa, input logic [31:0] wd, input logic c,
                       input logic [3:0] ra, input logic [3:0] rb);
    logic acc;
    w1 = w; wa1 = wa; wd1 = wd; c1 = c; ra1 = ra; rb1 = rb;
    acc = w && sw1 == 0 && wa != 0;
    chk("d1_pre_busy", 32'(busy1), 32'(sw1 > 0));
    @(posedge clk);
    #1;
    chk("d1_rd_data_a", rda1, ra == 0 ? 32'h0 : m1[ra]);
    chk("d1_rd_valid_a", 32'(rva1), ra == 0 ? 32'h1 : 32'(v1[ra]));
    chk("d1_rd_data_b", rdb1, rb == 0 ? 32'h0 : m1[rb]);
    chk("d1_rd_valid_b", 32'(rvb1), rb == 0 ? 32'h1 : 32'(v1[rb]));
    if (acc) begin m1[wa] = wd; v1[wa] = 1'b1; end
    if (sw1 > 0) begin m1[16-sw1] = '0; v1[16-sw1] = 1'b0; sw1--; end
    else if (c) sw1 = 16;
    chk("d1_busy", 32'(busy1), 32'(sw1 > 0));
    chk("d1_wr_ready", 32'(wrr1), 32'(sw1 == 0));
    w1 = 1'b0; c1 = 1'b0;
  endtask
  initial begin
    logic [15:0] vals [6];
    vals = '{16'hABCD, 16'h1234, 16'h3456, 16'h5678, 16'h9ABC, 16'hBEEF};
    rst_n = 1'b0;
    {w0, c0, wa0, wd0, ra0, rb0} = '0;
    {w1, c1, wa1, wd1, ra1, rb1} = '0;
    clear_models();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data_a", 32'(rda0), 0);
    chk("rst_rd_valid_a", 32'(rva0), 0);
    chk("rst_rd_data_b", 32'(rdb0), 0);
    chk("rst_rd_valid_b", 32'(rvb0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_wr_ready", 32'(wrr0), 1);
    chk("rst_d1_valid_a", 32'(rva1), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step0(1'b1, 3'(i), vals[i], 1'b0, 3'(i), 3'(7 - i));
    step0(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1);
    step0(1'b0, 3'd0, 16'h0, 1'b0, 3'd2, 3'd3);
    step0(1'b0, 3'd0, 16'h0, 1'b0, 3'd4, 3'd5);
    step0(1'b0, 3'd0, 16'h0, 1'b0, 3'd6, 3'd6);
    chk("unwritten6_data", 32'(rda0), 0);
    chk("unwritten6_valid", 32'(rva0), 0);
    step0(1'b1, 3'd5, 16'hCAFE, 1'b0, 3'd5, 3'd4);
    chk("bypass_a", 32'(rda0), 32'hCAFE);
    for (int i = 0; i < 8; i++) step0(1'b1, 3'(i), 16'(16'h1000 + i), 1'b0, 3'(i), 3'(i));
    step0(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd7);
    for (int i = 0; i < 8; i++) step0(i == 1, 3'd2, 16'h1111, 1'b0, 3'(i), 3'd2);
    for (int i = 0; i < 8; i++) step0(1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 3'(7 - i));
    chk("after_sweep_valid", 32'(rva0), 0);
    for (int i = 0; i < 60; i++)
      step0(1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 11) == 0,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    while (sw0 > 0) step0(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1);
    for (int i = 0; i < 8; i++) step0(1'b1, 3'(i), 16'(16'h2200 + i), 1'b0, 3'(i), 3'(i));
    step0(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd1);
    step0(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1);
    step0(1'b0, 3'd0, 16'h0, 1'b0, 3'd3, 3'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("midsweep_busy", 32'(busy0), 0);
    chk("midsweep_wr_ready", 32'(wrr0), 1);
    chk("midsweep_data_a", 32'(rda0), 0);
    chk("midsweep_valid_b", 32'(rvb0), 0);
    clear_models();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step0(1'b1, 3'd7, 16'h00FF, 1'b0, 3'd7, 3'd3);
    step0(1'b0, 3'd0, 16'h0, 1'b0, 3'd7, 3'd7);
    chk("post_reset_readback", 32'(rda0), 32'h00FF);
    step1(1'b1, 4'd0, 32'hDEADBEEF, 1'b0, 4'd0, 4'd15);
    step1(1'b1, 4'd15, 32'hDEADBEEF, 1'b0, 4'd15, 4'd0);
    step1(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd15);
    chk("zero_reg_data", rda1, 32'h0);
    chk("zero_reg_valid", 32'(rva1), 1);
    chk("addr15_data", rdb1, 32'hDEADBEEF);
    step1(1'b1, 4'd15, 32'h0BAD_F00D, 1'b0, 4'd15, 4'd15);
    chk("no_bypass", rda1, 32'hDEADBEEF);
    step1(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd0);
    for (int i = 0; i < 17; i++) step1(1'b1, 4'd9, 32'h1111, 1'b0, 4'(i), 4'd15);
    for (int i = 0; i < 60; i++)
      step1(1'($urandom), 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 15) == 0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
